uart_byte_tx: RTL and testbench
===============================

# uart_byte_tx

Byte-oriented UART transmitter that serialises 8-bit words into 8N1 frames, LSB first, on a single line. It is the transmit end of the serial link whose receive end feeds the transceiver chain. It generates legal framed traffic on the transceiver's serial `data` input in place of unframed random bits, and it provides the loopback source for end-to-end encoder/decoder checks. Upstream logic uses a valid/ready handshake; downstream sees only `q`.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `DATA_W`, 8: data bits per frame; fixed at 8 for this link.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  global enable; low freezes all sequential state except reset.
- `tx_data`  in  8  byte to send; sampled only on the handshake edge.
- `tx_valid`  in  1  upstream has a byte.
- `tx_ready`  out  1  `(state == IDLE) && en`; combinational.
- `q`  out  1  serial line; idles high; registered.
- `active`  out  1  high while a frame is on the line (START through STOP); registered.
- `done`  out  1  one-cycle pulse when a frame completes; registered.

## Operation
- States: IDLE → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: `q=1`, `active=0`. A handshake (`tx_valid && tx_ready` at a rising edge) does the following:
  - latches `tx_data` into the shift register;
  - clears the baud counter and bit index;
  - moves to START.
- START: `q=0` for CLKS_PER_BIT cycles.
- DATA: `q = shift[0]`. The register shifts right once per bit period. There are 8 bits, LSB first; the bit index runs 0..7.
- PARITY (macro only): one bit period carrying the parity bit.
- STOP: `q=1` for CLKS_PER_BIT cycles, then go to IDLE and assert `done` for exactly that one cycle.
- Baud counter: width `$clog2(CLKS_PER_BIT)`. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on the bit tick. The bit tick is `count == CLKS_PER_BIT-1`, and all state and bit advances happen on the tick.
- `en` low during a frame: the counter, state, shift register and `q` hold. `tx_ready=0`. `done` does not pulse. When `en` returns, the frame resumes exactly where it stopped.
- `rst` low at any time: the frame is aborted immediately, with no glitch beyond the asynchronous transition. Outputs go to their reset values.
- `tx_valid` while busy: ignored, with no side effects. Upstream holds the byte until `tx_ready`.

## Timing
- Reset values: `q=1`, `active=0`, `done=0`, state IDLE, counter 0, shift register 0. `tx_ready` follows `en` during and after reset.
- Handshake at edge k:
  - `q` falls and `active` rises in cycle k+1;
  - the start bit occupies cycles k+1..k+N, where N = CLKS_PER_BIT;
  - data bit i occupies cycles k+1+(i+1)·N .. k+(i+2)·N;
  - the stop bit occupies cycles k+1+9N .. k+10N.
- Completion: `done=1`, `active=0` and `tx_ready=1` all occur in cycle k+10N+1. Frame period is 10N cycles (11N with parity).
- Back-to-back frames: a handshake in the `done` cycle starts the next frame in the following cycle. The minimum line gap is 1 idle-high cycle beyond the stop bit; the throughput is 10N+1 cycles per byte.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - the PARITY state is compiled in, inserted between the last data bit and STOP;
  - the parity bit is even parity, `^data`;
  - the frame is 11 bit periods and `done` comes at k+11N+1.
- Undefined: the PARITY state and its logic are absent, and the frame is 8N1 with a length of 10N.

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - `UART_DATA_W = 8`;
  - the default `CLKS_PER_BIT`.
  - The future receiver reuses it.
- One sub-module, `uart_baud_gen`: a counter with `clk`, `rst`, `en` and `clear` inputs and a `bit_tick` output. The FSM, shift register and output registers stay in `uart_byte_tx`.

## Test plan
- Reset mid-frame: at CLKS_PER_BIT=4, send 0xA5, then drop `rst` during DATA bit 3 → `q=1`, `active=0`, `done=0` immediately. After release, `tx_ready=1` and the next byte 0x3C is sent cleanly.
- Single byte: N=4, send 0xA5 → `q` carries 0 (×4), 1,0,1,0,0,1,0,1 (×4 each), 1 (×4). `done` pulses exactly 41 cycles after the handshake; the monitor decodes 0xA5.
- Back-to-back: `tx_valid` held high with 0x00 then 0xFF → the second start bit begins 42 cycles after the first handshake edge. There is exactly one extra idle-high cycle, and both bytes decode correctly.
- Enable stall: `en=0` for 7 cycles in the middle of data bit 5 of 0x81 → `q` holds its value, and `done` arrives 7 cycles later than the nominal 41.
- Busy ignore: pulse `tx_valid` with 0x55 while `active=1` → no effect on the line. Only the original byte is transmitted, and `tx_ready` stays 0 until `done`.
- Parity build (`UART_TX_PARITY_EN`): 0x07 → parity bit 1. 0xA5 → parity bit 0. `done` comes at 45 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame width, default bit period
// and the even-parity helper. The transmitter uses it now; the receiver will
// reuse it.
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    localparam logic [2:0] UART_ST_IDLE   = 3'd0;
    localparam logic [2:0] UART_ST_START  = 3'd1;
    localparam logic [2:0] UART_ST_DATA   = 3'd2;
    localparam logic [2:0] UART_ST_PARITY = 3'd3;
    localparam logic [2:0] UART_ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = UART_ST_IDLE,
        START  = UART_ST_START,
        DATA   = UART_ST_DATA,
        PARITY = UART_ST_PARITY,
        STOP   = UART_ST_STOP
    } uart_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the last count as
// the bit tick; clear holds it at zero, en low freezes it.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic bit_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    assign bit_tick = (count == LAST);

    // Counter advances only while enabled; wraps on the tick or when cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (en) begin
            if (clear || bit_tick) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// Byte-oriented UART transmitter: 8N1 frames, LSB first, valid/ready input.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
// rst is asynchronous and active-low; en low freezes the whole frame.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_W       = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              q,
    output logic              active,
    output logic              done
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    uart_state_e       state, state_nxt;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic              q_r, q_nxt;
    logic              active_r, active_nxt;
    logic              done_r, done_nxt;
    logic              bit_tick;
    logic              handshake;
`ifdef UART_TX_PARITY_EN
    logic              parity_r, parity_nxt;
`endif

    assign tx_ready  = (state == IDLE) && en;
    assign handshake = tx_valid && tx_ready;
    assign q         = q_r;
    assign active    = active_r;
    assign done      = done_r;

    // The counter is parked at zero while idle, so every frame starts on a
    // fresh bit period right after the handshake.
    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .clear   (state == IDLE),
        .bit_tick(bit_tick)
    );

    // State register; frozen while en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Next state plus next values of the line, shifter and status outputs.
    // q is computed for the cycle after the edge so the line is registered.
    always_comb begin
        state_nxt  = state;
        shift_nxt  = shift;
        idx_nxt    = idx;
        q_nxt      = q_r;
        active_nxt = active_r;
        done_nxt   = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nxt = parity_r;
`endif
        case (state)
            IDLE: begin
                q_nxt      = 1'b1;
                active_nxt = 1'b0;
                if (handshake) begin
                    state_nxt  = START;
                    shift_nxt  = tx_data;
                    idx_nxt    = '0;
                    q_nxt      = 1'b0;
                    active_nxt = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_nxt = even_parity(tx_data);
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_nxt = DATA;
                    q_nxt     = shift[0];
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        q_nxt     = parity_r;
`else
                        state_nxt = STOP;
                        q_nxt     = 1'b1;
`endif
                    end else begin
                        shift_nxt = shift >> 1;
                        q_nxt     = shift[1];
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_nxt = STOP;
                    q_nxt     = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_nxt  = IDLE;
                    q_nxt      = 1'b1;
                    active_nxt = 1'b0;
                    done_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt  = IDLE;
                q_nxt      = 1'b1;
                active_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers. While en is low everything holds except
    // done, which is forced low so a stalled frame never reports completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift    <= '0;
            idx      <= '0;
            q_r      <= 1'b1;
            active_r <= 1'b0;
            done_r   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_r <= 1'b0;
`endif
        end else if (en) begin
            shift    <= shift_nxt;
            idx      <= idx_nxt;
            q_r      <= q_nxt;
            active_r <= active_nxt;
            done_r   <= done_nxt;
`ifdef UART_TX_PARITY_EN
            parity_r <= parity_nxt;
`endif
        end else begin
            done_r   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Self-checking bench for uart_byte_tx at CLKS_PER_BIT = 4.
// Honours UART_TX_PARITY_EN when the build defines it.
module tb_uart_byte_tx;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       q;
    logic       active;
    logic       done;

    int checks = 0;
    int errors = 0;

    uart_byte_tx #(
        .CLKS_PER_BIT(N),
        .DATA_W      (8)
    ) dut (
        .clk     (clk),
        .rst     (rst_n),
        .en      (en),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .q       (q),
        .active  (active),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Edge counter: after rising edge k, cyc == k and the cycle is labelled k+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc + 1);
        end
    endtask

    // Behavioural model: a frame is a position counter over FRAME*N
    // enabled cycles; the line value is looked up from the frame bit number.
    logic       m_busy = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_byte = '0;
    logic       m_done = 1'b0;
    int         hs_edge = 0;
    int         hs_count = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_pos  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (en) begin
                if (!m_busy) begin
                    if (tx_valid) begin
                        m_busy   <= 1'b1;
                        m_pos    <= 1;
                        m_byte   <= tx_data;
                        hs_edge  <= cyc + 1;
                        hs_count <= hs_count + 1;
                    end
                end else if (m_pos == FRAME * N) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end else begin
                    m_pos <= m_pos + 1;
                end
            end
        end
    end

    function automatic logic model_q();
        int j;
        if (!m_busy) return 1'b1;
        j = (m_pos - 1) / N;
        if (j == 0) return 1'b0;
        if (j <= 8) return m_byte[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^m_byte;
`endif
        return 1'b1;
    endfunction

    function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b01, b, 1'b0};
`endif
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        check("q", q, model_q());
        check("active", active, m_busy);
        check("done", done, m_done);
        check("tx_ready", tx_ready, !m_busy && en);
    end

    // Done monitor.
    int done_cnt = 0;
    int last_done = 0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt  <= done_cnt + 1;
            last_done <= cyc + 1;
        end
    end

    task automatic wait_hs(output int k);
        int start;
        bit got;
        start = hs_count;
        got   = 1'b0;
        k     = cyc;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            #1;
            if (hs_count != start) begin
                got = 1'b1;
                k   = hs_edge;
            end
        end
        check("handshake_seen", got, 1'b1);
    endtask

    task automatic wait_done(input int k, input int lat, input string name);
        int start;
        bit got;
        start = done_cnt;
        got   = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt != start) got = 1'b1;
        end
        check({name, "_done_seen"}, got, 1'b1);
        if (got) check({name, "_done_latency"}, last_done - k, lat);
    endtask

    // Samples the middle of each bit period of a frame handshaken at edge k.
    task automatic decode(input int k, output logic [10:0] line);
        int target;
        line = '0;
        for (int j = 0; j < FRAME; j++) begin
            target = k + 1 + j * N + N / 2;
            while (cyc + 1 < target) @(negedge clk);
            line[j] = q;
        end
    endtask

    task automatic start_byte(input logic [7:0] b, output int k);
        @(posedge clk);
        #1;
        tx_data  = b;
        tx_valid = 1'b1;
        wait_hs(k);
        tx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not end, %0d checks", checks);
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int k, k2;
        logic [10:0] line;

        rst_n    = 1'b0;
        en       = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", q, 1'b1);
        check("rst_active", active, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ready_en1", tx_ready, 1'b1);
        en = 1'b0;
        #1;
        check("rst_ready_en0", tx_ready, 1'b0);
        en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Single byte 0xA5.
        start_byte(8'hA5, k);
        decode(k, line);
`ifdef UART_TX_PARITY_EN
        check("a5_line", line, 11'h54A);
        check("a5_parity", line[9], 1'b0);
        wait_done(k, 45, "a5");
`else
        check("a5_line", line, 11'h34A);
        wait_done(k, 41, "a5");
`endif
        check("a5_byte", line[8:1], 8'hA5);
        idle(3);

        // Back-to-back 0x00 then 0xFF with tx_valid held high.
        @(posedge clk);
        #1;
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        wait_hs(k);
        tx_data = 8'hFF;
        decode(k, line);
        check("b2b_first", line, frame_of(8'h00));
        wait_hs(k2);
        tx_valid = 1'b0;
        check("b2b_gap", k2 - k, FRAME * N + 1);
        decode(k2, line);
        check("b2b_second", line, frame_of(8'hFF));
        wait_done(k2, FRAME * N + 1, "b2b");
        idle(3);

        // Enable stall of 7 cycles in the middle of data bit 5 of 0x81.
        start_byte(8'h81, k);
        while (cyc < k + 25) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
            check("stall_q", q, 1'b0);
            check("stall_ready", tx_ready, 1'b0);
        end
        en = 1'b1;
        wait_done(k, FRAME * N + 1 + 7, "stall");
        idle(3);

        // Busy ignore: a 0x55 pulse during the frame must not disturb 0xC3.
        start_byte(8'hC3, k);
        @(posedge clk);
        #1;
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        check("busy_ready", tx_ready, 1'b0);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        decode(k, line);
        check("busy_line", line, frame_of(8'hC3));
        wait_done(k, FRAME * N + 1, "busy");
        idle(3);

        // Reset in the middle of data bit 3, then a clean 0x3C.
        start_byte(8'hA5, k);
        while (cyc < k + 17) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_q", q, 1'b1);
        check("abort_active", active, 1'b0);
        check("abort_done", done, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort_ready", tx_ready, 1'b1);
        rst_n = 1'b1;
        idle(2);
        start_byte(8'h3C, k);
        decode(k, line);
        check("after_rst_line", line, frame_of(8'h3C));
        wait_done(k, FRAME * N + 1, "after_rst");
        idle(3);

`ifdef UART_TX_PARITY_EN
        // Parity of 0x07 is 1.
        start_byte(8'h07, k);
        decode(k, line);
        check("p07_parity", line[9], 1'b1);
        check("p07_line", line, 11'h60E);
        wait_done(k, 45, "p07");
        idle(3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
